// File: rtl/ssd_scan_ctrl.sv
// Seven-segment display owner arbitration and 8-digit scan sequencer.
// Picks the hex or BCD counter once per frame, snapshots its value, then scans
// the eight digits with a one-cycle dead-time blank between them.
//
// state | meaning
// IDLE  | display dark, no owner; waits for a refresh tick with a request
// LATCH | arbitrate, register grants, snapshot owner value, restart at digit 0
// BLANK | dead time between digits, all anodes off
// DRIVE | current digit lit until the next refresh tick
module ssd_scan_ctrl #(
  parameter int unsigned clk_counter_value = 99_999,
  parameter bit          blank_lead        = 1'b1
) (
  input  logic        ssd_scan_ctrl_clk,
  input  logic        ssd_scan_ctrl_rst,
  input  logic        ssd_scan_ctrl_hex_req,
  input  logic        ssd_scan_ctrl_bcd_req,
  input  logic        ssd_scan_ctrl_sel,
  input  logic [31:0] ssd_scan_ctrl_hex_val,
  input  logic [31:0] ssd_scan_ctrl_bcd_val,
  output logic        ssd_scan_ctrl_hex_gnt,
  output logic        ssd_scan_ctrl_bcd_gnt,
  output logic [6:0]  ssd_scan_ctrl_cc,
  output logic [7:0]  ssd_scan_ctrl_an,
  output logic [2:0]  ssd_scan_ctrl_idx,
  output logic        ssd_scan_ctrl_frame_done
);

  localparam int DIV_W = (clk_counter_value == 0) ? 1 : $clog2(clk_counter_value + 1);
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(clk_counter_value);

  typedef enum logic [1:0] {IDLE, LATCH, BLANK, DRIVE} state_t;

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div, div_nxt;
  logic [2:0]        idx_nxt;
  logic [31:0]       frame, frame_nxt;
  logic              hex_gnt_nxt, bcd_gnt_nxt;
  logic              tick, any_req, win_bcd;
  logic [31:0]       shifted;
  logic              lead_blank;
  logic [7:0]        an_nxt;
  logic [6:0]        cc_nxt;
  logic              frame_done_nxt;

  // Active-low glyphs {g,f,e,d,c,b,a}; a BCD owner shows a dash for A-F.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib, input logic bcd);
    logic [6:0] g;
    g = 7'h7F;
    case (nib)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      4'hF: g = 7'b0001110;
      default: g = 7'h7F;
    endcase
    if (bcd && (nib > 4'd9)) g = 7'b0111111;
    return g;
  endfunction

  // Next state, frame bookkeeping, divider, and the output values for the next cycle.
  always_comb begin
    tick           = (div == DIV_TC);
    any_req        = ssd_scan_ctrl_hex_req | ssd_scan_ctrl_bcd_req;
    win_bcd        = ssd_scan_ctrl_bcd_req & (~ssd_scan_ctrl_hex_req | ssd_scan_ctrl_sel);
    state_nxt      = state;
    idx_nxt        = ssd_scan_ctrl_idx;
    frame_nxt      = frame;
    hex_gnt_nxt    = ssd_scan_ctrl_hex_gnt;
    bcd_gnt_nxt    = ssd_scan_ctrl_bcd_gnt;

    case (state)
      IDLE: begin
        if (tick && any_req) state_nxt = LATCH;
      end
      LATCH: begin
        idx_nxt = 3'd0;
        if (any_req) begin
          hex_gnt_nxt = ~win_bcd;
          bcd_gnt_nxt = win_bcd;
          frame_nxt   = win_bcd ? ssd_scan_ctrl_bcd_val : ssd_scan_ctrl_hex_val;
          state_nxt   = BLANK;
        end else begin
          // requester vanished before arbitration: nothing to show
          hex_gnt_nxt = 1'b0;
          bcd_gnt_nxt = 1'b0;
          state_nxt   = IDLE;
        end
      end
      BLANK: begin
        state_nxt = DRIVE;
      end
      DRIVE: begin
        if (tick) begin
          if (ssd_scan_ctrl_idx != 3'd7) begin
            idx_nxt   = ssd_scan_ctrl_idx + 3'd1;
            state_nxt = BLANK;
          end else if (any_req) begin
            state_nxt = LATCH;
          end else begin
            idx_nxt     = 3'd0;
            hex_gnt_nxt = 1'b0;
            bcd_gnt_nxt = 1'b0;
            state_nxt   = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if ((state_nxt == DRIVE) && (state != DRIVE)) div_nxt = '0;
    else if (tick)                                div_nxt = '0;
    else                                          div_nxt = div + 1'b1;

    // digits above the most significant non-zero nibble are dark; digit 0 never is
    shifted    = frame_nxt >> {idx_nxt, 2'b00};
    lead_blank = blank_lead && (idx_nxt != 3'd0) && (shifted == 32'd0);

    an_nxt = 8'hFF;
    cc_nxt = 7'h7F;
    if (state_nxt == DRIVE) begin
      an_nxt = ~(8'h01 << idx_nxt);
      if (!lead_blank) cc_nxt = seg_decode(shifted[3:0], bcd_gnt_nxt);
    end
    frame_done_nxt = (state_nxt == DRIVE) && (idx_nxt == 3'd7) && (div_nxt == DIV_TC);
  end

  // All state and pins registered; reset darkens the display immediately.
  always_ff @(posedge ssd_scan_ctrl_clk or negedge ssd_scan_ctrl_rst) begin
    if (!ssd_scan_ctrl_rst) begin
      state                    <= IDLE;
      div                      <= '0;
      frame                    <= 32'd0;
      ssd_scan_ctrl_idx        <= 3'd0;
      ssd_scan_ctrl_hex_gnt    <= 1'b0;
      ssd_scan_ctrl_bcd_gnt    <= 1'b0;
      ssd_scan_ctrl_an         <= 8'hFF;
      ssd_scan_ctrl_cc         <= 7'h7F;
      ssd_scan_ctrl_frame_done <= 1'b0;
    end else begin
      state                    <= state_nxt;
      div                      <= div_nxt;
      frame                    <= frame_nxt;
      ssd_scan_ctrl_idx        <= idx_nxt;
      ssd_scan_ctrl_hex_gnt    <= hex_gnt_nxt;
      ssd_scan_ctrl_bcd_gnt    <= bcd_gnt_nxt;
      ssd_scan_ctrl_an         <= an_nxt;
      ssd_scan_ctrl_cc         <= cc_nxt;
      ssd_scan_ctrl_frame_done <= frame_done_nxt;
    end
  end

endmodule

// File: doc/ssd_scan_ctrl.md
# ssd_scan_ctrl

Display-ownership controller and 8-digit scan sequencer for the seven-segment display shared by the hex up-counter and the BCD up-counter. It arbitrates between the two counters' display requests and snapshots the winner's 32-bit value once per frame. It then time-multiplexes the eight anodes with a dead-time blank between digits and decodes each nibble to active-low cathodes. It sits between the counter datapaths and the board's `cc`/`an` pins.

## Interface
- `clk_counter_value`, default 99_999: refresh divider terminal count; each digit dwells `clk_counter_value+1` cycles.
- `blank_lead`, default 1: 1 = blank leading zero digits; 0 = show all eight digits.
- `ssd_scan_ctrl_clk` in 1: system clock, single clock domain.
- `ssd_scan_ctrl_rst` in 1: reset, asynchronous, active-low.
- `ssd_scan_ctrl_hex_req` in 1: hex counter requests the display.
- `ssd_scan_ctrl_bcd_req` in 1: BCD counter requests the display.
- `ssd_scan_ctrl_sel` in 1: tie-break when both request; 0 = hex wins, 1 = BCD wins.
- `ssd_scan_ctrl_hex_val` in 32: hex counter value, 8 nibbles.
- `ssd_scan_ctrl_bcd_val` in 32: BCD counter value, 8 nibbles.
- `ssd_scan_ctrl_hex_gnt` out 1: hex owns the current frame.
- `ssd_scan_ctrl_bcd_gnt` out 1: BCD owns the current frame.
- `ssd_scan_ctrl_cc` out 7: cathodes `{g,f,e,d,c,b,a}`, active-low.
- `ssd_scan_ctrl_an` out 8: anodes, active-low; bit i is digit i, where digit 0 is least significant.
- `ssd_scan_ctrl_idx` out 3: digit currently selected.
- `ssd_scan_ctrl_frame_done` out 1: one-cycle pulse on the last cycle of digit 7.

## Operation
- **Divider.** Counts 0 to `clk_counter_value`, then wraps to 0. `tick` is asserted on the terminal count. The divider is cleared on every entry to DRIVE and runs freely in all other states.
- **FSM states:**
  - IDLE: `an`=FF, `cc`=7F, grants 0. On `tick` with any request asserted, go to LATCH.
  - LATCH (1 cycle): arbitrate. A single requester wins. With both requesting, `sel` decides. Register the grants, snapshot the winner's value into the frame register, set `idx`=0, go to BLANK.
  - BLANK (1 cycle): `an`=FF and `cc`=7F (dead time), then go to DRIVE.
  - DRIVE: `an`=~(1<<idx) and `cc`=decode(frame nibble[idx]).
    - On `tick` with idx<7: idx+1, go to BLANK.
    - On `tick` with idx==7: pulse `frame_done`. If any request is asserted, go to LATCH (re-arbitrate); otherwise go to IDLE and clear the grants.
- **Stability within a frame.** Grants and the snapshot change only in LATCH. Request, `sel`, or value changes mid-frame have no effect until the next frame.
- **Decode.** Hex owner: 0–F with standard glyphs (0 = 7'b1000000, 8 = 7'b0000000, F = 7'b0001110). BCD owner: 0–9 as hex; nibbles A–F show a dash (7'b0111111).
- **Leading-zero blanking** (`blank_lead`=1): digits above the most significant non-zero nibble of the snapshot show `cc`=7F. Their anode is still driven. Digit 0 is never blanked, so a zero value shows "0".
- **Outputs.** All outputs are registered, with no combinational path from inputs to outputs.

## Timing
- **Reset.** Asserting reset (low), at any time including mid-frame, immediately forces:
  - state IDLE, divider 0, idx 0;
  - `an`=8'hFF, `cc`=7'h7F;
  - both grants 0, `frame_done` 0, frame register 0.
- **Reset release.** On release, the first `tick` occurs `clk_counter_value+1` cycles later.
- **Start latency.** With a tick in IDLE at cycle t, LATCH is at t+1, BLANK at t+2, and the first anode is low at t+3.
- **Per digit.** Each digit takes 1 BLANK cycle plus `clk_counter_value+1` DRIVE cycles.
- **Frame length.** A frame is 1 + 8·(clk_counter_value+2) cycles including LATCH. With `clk_counter_value`=0 this is 17 cycles.
- **Ownership change.** Switching owner takes effect only on a frame boundary; the worst-case wait is one full frame.
- **Exclusive outputs.**
  - At most one anode is low in any cycle.
  - At most one grant is high, and grants are never high in IDLE.

## Test plan
- **Reset values.** Hold reset low 5 cycles, then release with no requests (`clk_counter_value`=0). Required: `an`=FF and `cc`=7F throughout, grants 0, state stays IDLE.
- **Hex frame, blanking on.** `hex_req`=1, `hex_val`=32'h0000_3A7F. Required:
  - `hex_gnt`=1 from LATCH;
  - first anode low 3 cycles after the tick;
  - digits 0–3 show F, 7, A, 3;
  - digits 4–7 show `cc`=7F with their anode low;
  - `frame_done` pulses at cycle 17.
- **Tie-break and frame-boundary switch.** Both requests high, `sel`=1, `bcd_val`=32'h0000_0129. Required: `bcd_gnt`=1 and digits show 9, 2, 1. Toggling `sel` to 0 mid-frame must not change the grant until after `frame_done`; the next LATCH then grants hex.
- **BCD invalid nibble and zero value.** BCD owner with `bcd_val`=32'h0000_00B0. Required: digit 1 shows a dash (7'b0111111) and digit 0 shows "0". With `bcd_val`=0, only digit 0 shows "0".
- **Mid-frame changes.** Change `hex_val` during digit 3. Required: the displayed frame is unchanged. Deassert all requests in the same frame. Required: return to IDLE after digit 7, with `an`=FF and grants 0.
- **Reset mid-frame.** Assert reset during DRIVE of digit 5. Required: `an`=FF, `cc`=7F, and grants 0 in the same cycle, without waiting for a clock edge. After release, the bench sees a clean restart from LATCH at digit 0.
